muldiv_hilo_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair. It is the successor to the single-cycle HI/LO write path in the EX/WR stages.
- Sits beside the ALU in EX.
- Accepts MULT/MULTU/DIV/DIVU/MADD/MADDU/MTHI/MTLO.
- Raises busy so the hazard unit can stall MFHI/MFLO and further mul/div ops.
- Supports pipeline flush of an in-flight op.

---
 rtl/muldiv_hilo_unit_pkg.sv | 38 +++
 rtl/muldiv_hilo_unit_if.sv | 26 ++
 rtl/muldiv_hilo_unit_div_iter_core.sv | 52 +++++
 rtl/muldiv_hilo_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit: op codes, FSM
// state encoding and parameter legality helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 8;

  // Multiply latency must fit the shared counter and stay non-zero.
  function automatic bit mul_lat_ok(input int lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

  // Counter must hold both WIDTH-1 (divide) and MUL_LAT_MAX-1 (multiply).
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w > 3) ? w : 3;
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_hilo_unit_div_iter_core.sv
// Radix-2 restoring divider datapath: unsigned magnitudes in, one quotient
// bit per step. Sequencing and sign handling live in the parent.
module div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   trial_rem;
  logic [WIDTH:0]   trial_diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    trial_rem  = {rem_r, q_r[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, dvs_r};
  end

  // Quotient bits shift into q_r as dividend bits shift out of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r   <= '0;
      rem_r <= '0;
      dvs_r <= '0;
    end else if (load) begin
      q_r   <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
    end else if (step) begin
      if (!trial_diff[WIDTH]) begin
        rem_r <= trial_diff[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= trial_rem[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q_r;
  assign remainder = rem_r;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Multiplies take MUL_LAT busy cycles, divides WIDTH+1; flush aborts
// an in-flight op without touching HI/LO.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_hilo_unit_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  if (!mul_lat_ok(MUL_LAT)) begin : g_lat_check
    $error("muldiv_hilo_unit: MUL_LAT out of range 1..8");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_signed;
  logic             mul_acc;

  logic [WIDTH-1:0] div_a_raw;
  logic             div_zero;
  logic             q_neg;
  logic             r_neg;

  op_t                op_in;
  logic               div_signed_in;
  logic               a_neg_in;
  logic               b_neg_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               div_load;
  logic               div_step;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;

  assign op_in = op_t'(bus.op);

  // Operand magnitudes for the divider, taken straight from the request.
  always_comb begin
    div_signed_in = (op_in == OP_DIV);
    a_neg_in      = div_signed_in & bus.a[WIDTH-1];
    b_neg_in      = div_signed_in & bus.b[WIDTH-1];
    mag_a         = a_neg_in ? ('0 - bus.a) : bus.a;
    mag_b         = b_neg_in ? ('0 - bus.b) : bus.b;
    div_load      = (state == S_IDLE) && bus.start && !bus.flush &&
                    ((op_in == OP_DIV) || (op_in == OP_DIVU));
    div_step      = (state == S_DIV);
  end

  // Full-width product from latched operands; held stable for MUL_LAT cycles.
  always_comb begin
    ext_a      = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
    ext_b      = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
    product    = ext_a * ext_b;
    mul_result = mul_acc ? ({hi_q, lo_q} + product) : product;
  end

  // Sign correction of the unsigned divide result.
  always_comb begin
    q_fix = q_neg ? ('0 - quot) : quot;
    r_fix = r_neg ? ('0 - rem)  : rem;
  end

  div_iter_core #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quot),
    .remainder (rem)
  );

  // Control FSM plus HI/LO ownership; flush aborts with no write and no done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      mul_acc    <= 1'b0;
      div_a_raw  <= '0;
      div_zero   <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            case (op_in)
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                mul_a      <= bus.a;
                mul_b      <= bus.b;
                mul_signed <= (op_in == OP_MULT) || (op_in == OP_MADD);
                mul_acc    <= (op_in == OP_MADD) || (op_in == OP_MADDU);
                cnt        <= CW'(MUL_LAT - 1);
                state      <= S_MUL;
              end
              default: begin
                div_a_raw <= bus.a;
                div_zero  <= (bus.b == '0);
                q_neg     <= a_neg_in ^ b_neg_in;
                r_neg     <= a_neg_in;
                cnt       <= CW'(WIDTH - 1);
                state     <= S_DIV;
              end
            endcase
          end
        end
        S_MUL: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            {hi_q, lo_q} <= mul_result;
            done_q       <= 1'b1;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_q   <= div_zero ? div_a_raw : r_fix;
            lo_q   <= div_zero ? '1 : q_fix;
            done_q <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: vector table through a result scoreboard,
// plus hand sequences for MTHI/MTLO/MADD, flush, start-while-busy and reset.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

  muldiv_hilo_unit #(
    .WIDTH   (W),
    .MUL_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cycles;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic fl);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.flush = fl;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  // Counts busy cycles from the next negedge, then checks the popped result.
  task automatic collect(input string name, input int exp_cycles);
    int   cnt;
    exp_t e;
    cnt = 0;
    @(negedge clk);
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
    chk({name, "_done"}, {63'b0, bus.done}, 64'd1);
    if (sb.size() == 0) begin
      chk({name, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_hi"}, {32'b0, bus.hi}, {32'b0, e.hi});
      chk({name, "_lo"}, {32'b0, bus.lo}, {32'b0, e.lo});
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(negedge clk);
    chk({name, "_done_drop"}, {63'b0, bus.done}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, LAT,  "mult_neg2x3"};
    vecs[1] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       W+1,  "divu_100_7"};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, W+1,  "div_m7_2"};
    vecs[3] = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, W+1,  "div_by_zero"};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, W+1,  "div_min_m1"};
    vecs[5] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT,  "multu_max"};
    vecs[6] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, W+1,  "divu_by_zero"};
    vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, W+1,  "div_7_m2"};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, LAT,  "mult_min_sq"};
    vecs[9] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, W+1,  "divu_max_1"};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    rst       = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("reset_busy", {63'b0, bus.busy}, 64'd0);
    chk("reset_done", {63'b0, bus.done}, 64'd0);
    chk("reset_hi", {32'b0, bus.hi}, 64'd0);
    chk("reset_lo", {32'b0, bus.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;

    // Table-driven results through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo});
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      collect(vecs[i].name, vecs[i].cycles);
    end

    // MTLO / MTHI write immediately without busy, then MADDU / MADD accumulate.
    drive(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("mtlo_busy", {63'b0, bus.busy}, 64'd0);
    chk("mtlo_lo", {32'b0, bus.lo}, 64'hFFFFFFFF);
    drive(OP_MTHI, 32'd0, 32'd0, 1'b0);
    chk("mthi_busy", {63'b0, bus.busy}, 64'd0);
    chk("mthi_hi", {32'b0, bus.hi}, 64'd0);
    @(negedge clk);
    chk("mthi_no_done", {63'b0, bus.done}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'hFFFFFFFF;
    sb.push_back('{32'd1, 32'd0});
    drive(OP_MADDU, 32'd1, 32'd1, 1'b0);
    collect("maddu", LAT);
    sb.push_back('{32'd0, 32'hFFFFFFFF});
    drive(OP_MADD, 32'hFFFFFFFF, 32'd1, 1'b0);
    collect("madd_neg", LAT);

    // Flush at divide busy cycle 10.
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    chk("flush_div_busy_before", {63'b0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_div_busy_after", {63'b0, bus.busy}, 64'd0);
    chk("flush_div_hi", {32'b0, bus.hi}, {32'b0, m_hi});
    chk("flush_div_lo", {32'b0, bus.lo}, {32'b0, m_lo});
    @(negedge clk);
    chk("flush_div_no_done", {63'b0, bus.done}, 64'd0);
    repeat (35) @(negedge clk);
    chk("flush_div_stays_idle", {63'b0, bus.busy | bus.done}, 64'd0);
    chk("flush_div_lo_later", {32'b0, bus.lo}, {32'b0, m_lo});

    // Start pulsed while busy is ignored; the divide completes normally.
    sb.push_back('{32'd0, 32'd100});
    drive(OP_DIVU, 32'd1000, 32'd10, 1'b0);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MTLO;
    bus.a     = 32'h12345678;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("busy_start_lo_kept", {32'b0, bus.lo}, {32'b0, m_lo});
    collect("busy_start_divu", W + 1 - 5);

    // Flush on the last multiply cycle wins over the write.
    drive(OP_MULT, 32'd5, 32'd5, 1'b0);
    repeat (LAT) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_last_busy", {63'b0, bus.busy}, 64'd0);
    chk("flush_last_hi", {32'b0, bus.hi}, {32'b0, m_hi});
    chk("flush_last_lo", {32'b0, bus.lo}, {32'b0, m_lo});
    @(negedge clk);
    chk("flush_last_no_done", {63'b0, bus.done}, 64'd0);

    // Flush together with start in IDLE drops the request, MTHI included.
    drive(OP_MTHI, 32'h0000ABCD, 32'd0, 1'b1);
    chk("flush_idle_busy", {63'b0, bus.busy}, 64'd0);
    chk("flush_idle_hi", {32'b0, bus.hi}, {32'b0, m_hi});

    // Async reset in the middle of a multiply.
    drive(OP_MULT, 32'd7, 32'd9, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("async_rst_done", {63'b0, bus.done}, 64'd0);
    chk("async_rst_hi", {32'b0, bus.hi}, 64'd0);
    chk("async_rst_lo", {32'b0, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{32'd0, 32'd12});
    drive(OP_MULTU, 32'd3, 32'd4, 1'b0);
    collect("post_reset_multu", LAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
